// File: rtl/ucsbece154b_issue_pkg.sv
// Shared definitions for the dual-issue instruction queue: NOP encoding,
// default depth and the per-cycle pop-count encoding.
package ucsbece154b_issue_pkg;

    localparam logic [31:0] IQ_NOP           = 32'h00000013;
    localparam int          IQ_DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

endpackage

// File: rtl/ucsbece154b_iq_storage.sv
// Circular entry array for the issue queue: two write ports at tail and
// tail+1, two combinational read ports at head and head+1. Addresses wrap
// modulo DEPTH through natural pointer overflow (DEPTH is a power of two).
module ucsbece154b_iq_storage
    import ucsbece154b_issue_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    parameter int IW    = 32,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic [PW-1:0]   head_i,
    input  logic [PW-1:0]   tail_i,
    input  logic            we0_i,
    input  logic            we1_i,
    input  logic [2*IW-1:0] wdata0_i,
    input  logic [2*IW-1:0] wdata1_i,
    output logic [2*IW-1:0] rdata0_o,
    output logic [2*IW-1:0] rdata1_o
);

    logic [2*IW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   tail1;
    logic [PW-1:0]   head1;

    assign tail1 = tail_i + PW'(1);
    assign head1 = head_i + PW'(1);

    assign rdata0_o = mem_q[head_i];
    assign rdata1_o = mem_q[head1];

    // Entry payload is data only; occupancy is tracked by the owner, so no reset.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[tail_i] <= wdata0_i;
        if (we1_i) mem_q[tail1]  <= wdata1_i;
    end

endmodule

// File: rtl/ucsbece154b_issue_queue.sv
// Dual-issue instruction queue between fetch and the dual-slot decode
// controller. Presents the two oldest entries as decode slots 1 and 2 and
// retires 0/1/2 per cycle based on StallD_i / Slot2Hold_i.
// Optional feature macro: ISSUE_QUEUE_BYPASS_EN -- when defined, fetched
// instructions fill empty decode slots in the same cycle (0-cycle latency).
module ucsbece154b_issue_queue
    import ucsbece154b_issue_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    parameter int IW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_valid_i,
    input  logic [1:0]             fetch_count_i,
    input  logic [IW-1:0]          fetch_instr0_i,
    input  logic [IW-1:0]          fetch_pc0_i,
    input  logic [IW-1:0]          fetch_instr1_i,
    input  logic [IW-1:0]          fetch_pc1_i,
    output logic                   fetch_ready_o,
    input  logic                   StallD_i,
    input  logic                   Slot2Hold_i,
    input  logic                   Flush_i,
    output logic [IW-1:0]          InstrD_o,
    output logic [IW-1:0]          PCD_o,
    output logic                   ValidD_o,
    output logic [IW-1:0]          InstrD2_o,
    output logic [IW-1:0]          PCD2_o,
    output logic                   ValidD2_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0] NOP_C   = IW'(IQ_NOP);

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            flush;
    logic [1:0]      push_n, byp_n, qpop_n, wr_n, pop_v;
    pop_e            pop;
    logic [CW-1:0]   avail;
    logic [2*IW-1:0] rd0, rd1, wd0, wd1;
    logic            we0, we1;

    // Reset mid-stream is treated exactly like a mispredict flush.
    assign flush         = reset | Flush_i;
    assign fetch_ready_o = (DEPTH_C - count_q) >= CW'(2);
    assign count_o       = count_q;
    assign pop_v         = pop;

    // Accepted fetch count; pushes while not ready are dropped.
    always_comb begin
        push_n = 2'd0;
        if (fetch_valid_i && !flush && fetch_ready_o)
            push_n = (fetch_count_i >= 2'd2) ? 2'd2 : fetch_count_i;
    end

    // Pop decision from the entries visible to decode this cycle.
    always_comb begin
`ifdef ISSUE_QUEUE_BYPASS_EN
        avail = (count_q < CW'(2)) ? count_q + CW'(push_n) : count_q;
`else
        avail = count_q;
`endif
        pop = POP_NONE;
        if (!StallD_i && avail != '0)
            pop = (Slot2Hold_i || avail == CW'(1)) ? POP_ONE : POP_TWO;
    end

    // Split pops into queue entries vs. bypassed fetches; only the rest is written.
    always_comb begin
        byp_n = 2'd0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (CW'(pop_v) > count_q)
            byp_n = pop_v - count_q[1:0];
`endif
        qpop_n = pop_v - byp_n;
        wr_n   = push_n - byp_n;
        wd0    = (byp_n == 2'd1) ? {fetch_pc1_i, fetch_instr1_i}
                                 : {fetch_pc0_i, fetch_instr0_i};
        wd1    = {fetch_pc1_i, fetch_instr1_i};
        we0    = wr_n >= 2'd1;
        we1    = wr_n == 2'd2;
    end

    // Pointer and occupancy next state; flush clears everything.
    always_comb begin
        head_d  = head_q + PW'(qpop_n);
        tail_d  = tail_q + PW'(wr_n);
        count_d = count_q - CW'(qpop_n) + CW'(wr_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state register (reset handled via flush in next-state logic).
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    ucsbece154b_iq_storage #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_storage (
        .clk      (clk),
        .head_i   (head_q),
        .tail_i   (tail_q),
        .we0_i    (we0),
        .we1_i    (we1),
        .wdata0_i (wd0),
        .wdata1_i (wd1),
        .rdata0_o (rd0),
        .rdata1_o (rd1)
    );

    // Decode slot outputs; invalid slots show NOP at PC 0.
    always_comb begin
        InstrD_o  = NOP_C;
        PCD_o     = '0;
        ValidD_o  = 1'b0;
        InstrD2_o = NOP_C;
        PCD2_o    = '0;
        ValidD2_o = 1'b0;
        if (count_q >= CW'(1)) begin
            {PCD_o, InstrD_o} = rd0;
            ValidD_o          = 1'b1;
        end
        if (count_q >= CW'(2)) begin
            {PCD2_o, InstrD2_o} = rd1;
            ValidD2_o           = 1'b1;
        end
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (count_q == CW'(0) && push_n >= 2'd1) begin
            {PCD_o, InstrD_o} = {fetch_pc0_i, fetch_instr0_i};
            ValidD_o          = 1'b1;
        end
        if (count_q == CW'(0) && push_n == 2'd2) begin
            {PCD2_o, InstrD2_o} = {fetch_pc1_i, fetch_instr1_i};
            ValidD2_o           = 1'b1;
        end
        if (count_q == CW'(1) && push_n >= 2'd1) begin
            {PCD2_o, InstrD2_o} = {fetch_pc0_i, fetch_instr0_i};
            ValidD2_o           = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_ucsbece154b_issue_queue.sv
// Scoreboard bench for ucsbece154b_issue_queue: stimulus queues expected
// {pc, instr} pairs as fetches are issued; a negedge monitor pops and
// compares every entry decode consumes.
module tb_ucsbece154b_issue_queue;

    localparam int          DEPTH = 8;
    localparam int          IW    = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_valid_i = 1'b0;
    logic [1:0]    fetch_count_i = 2'd0;
    logic [IW-1:0] fetch_instr0_i = '0, fetch_pc0_i = '0;
    logic [IW-1:0] fetch_instr1_i = '0, fetch_pc1_i = '0;
    logic          fetch_ready_o;
    logic          StallD_i = 1'b0, Slot2Hold_i = 1'b0, Flush_i = 1'b0;
    logic [IW-1:0] InstrD_o, PCD_o, InstrD2_o, PCD2_o;
    logic          ValidD_o, ValidD2_o;
    logic [3:0]    count_o;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sbq [$];

    ucsbece154b_issue_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_count_i  (fetch_count_i),
        .fetch_instr0_i (fetch_instr0_i),
        .fetch_pc0_i    (fetch_pc0_i),
        .fetch_instr1_i (fetch_instr1_i),
        .fetch_pc1_i    (fetch_pc1_i),
        .fetch_ready_o  (fetch_ready_o),
        .StallD_i       (StallD_i),
        .Slot2Hold_i    (Slot2Hold_i),
        .Flush_i        (Flush_i),
        .InstrD_o       (InstrD_o),
        .PCD_o          (PCD_o),
        .ValidD_o       (ValidD_o),
        .InstrD2_o      (InstrD2_o),
        .PCD2_o         (PCD2_o),
        .ValidD2_o      (ValidD2_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic consume(input string nm, input logic [31:0] pc, input logic [31:0] instr);
        logic [63:0] e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_extra: got pc %h expected no entry", nm, pc);
        end else begin
            e = sbq.pop_front();
            check({nm, "_pc"}, pc, e[63:32]);
            check({nm, "_instr"}, instr, e[31:0]);
        end
    endtask

    // Monitor: every slot retired this cycle must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset || Flush_i) sbq.delete();
        else if (!StallD_i) begin
            if (ValidD_o) consume("slot1", PCD_o, InstrD_o);
            if (ValidD2_o && !Slot2Hold_i) consume("slot2", PCD2_o, InstrD2_o);
        end
    end

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid_i = 1'b0;
        fetch_count_i = 2'd0;
        StallD_i      = 1'b0;
        Slot2Hold_i   = 1'b0;
        Flush_i       = 1'b0;
    endtask

    task automatic fetch(input int n, input logic [31:0] pc0, input logic [31:0] i0,
                         input logic [31:0] i1, input bit expect_it);
        fetch_valid_i  = 1'b1;
        fetch_count_i  = 2'(n);
        fetch_pc0_i    = pc0;
        fetch_instr0_i = i0;
        fetch_pc1_i    = pc0 + 32'd4;
        fetch_instr1_i = i1;
        if (expect_it) begin
            sbq.push_back({pc0, i0});
            if (n == 2) sbq.push_back({pc0 + 32'd4, i1});
        end
    endtask

    initial begin
        int n;
        int cyc;

        // Reset state
        step();
        step();
        check("rst_valid", 32'(ValidD_o), 0);
        check("rst_valid2", 32'(ValidD2_o), 0);
        check("rst_instr", InstrD_o, NOP);
        check("rst_instr2", InstrD2_o, NOP);
        check("rst_pc", PCD_o, 0);
        check("rst_pc2", PCD2_o, 0);
        check("rst_ready", 32'(fetch_ready_o), 1);
        check("rst_count", 32'(count_o), 0);
        reset = 1'b0;
        idle();

        // Basic pair: 1-cycle latency, both consumed next cycle
        fetch(2, 32'h0, 32'h00500093, 32'h00A00113, 1);
        step();
        idle();
        check("t1_valid", 32'(ValidD_o), 1);
        check("t1_valid2", 32'(ValidD2_o), 1);
        check("t1_pc", PCD_o, 32'h0);
        check("t1_pc2", PCD2_o, 32'h4);
        check("t1_count", 32'(count_o), 2);
        step();
        check("t1_empty_valid", 32'(ValidD_o), 0);
        check("t1_empty_instr", InstrD_o, NOP);
        check("t1_empty_count", 32'(count_o), 0);

        // Slot2Hold retires only slot 1
        StallD_i = 1'b1;
        fetch(2, 32'h0, ins(32'h0), ins(32'h4), 1);
        step();
        fetch(2, 32'h8, ins(32'h8), ins(32'hC), 1);
        step();
        idle();
        Slot2Hold_i = 1'b1;
        step();
        idle();
        check("t2_pc", PCD_o, 32'h4);
        check("t2_pc2", PCD2_o, 32'h8);
        check("t2_count", 32'(count_o), 3);
        step();
        step();
        check("t2_drained", 32'(count_o), 0);

        // Stall fill to full (wraps pointers), dropped overflow push, ordered drain
        for (int k = 0; k < 4; k++) begin
            StallD_i = 1'b1;
            fetch(2, 32'h200 + 32'(8 * k), ins(32'h200 + 32'(8 * k)), ins(32'h204 + 32'(8 * k)), 1);
            step();
            check("t3_count", 32'(count_o), 32'(2 * (k + 1)));
            check("t3_ready", 32'(fetch_ready_o), (k < 3) ? 1 : 0);
        end
        fetch(2, 32'h300, ins(32'h300), ins(32'h304), 0);
        step();
        check("t3_overflow_count", 32'(count_o), 8);
        idle();
        for (int k = 0; k < 4; k++) step();
        check("t3_drained", 32'(count_o), 0);
        check("t3_sb_empty", 32'(sbq.size()), 0);

        // Flush at count 5 with simultaneous fetch
        StallD_i = 1'b1;
        fetch(2, 32'h400, ins(32'h400), ins(32'h404), 1);
        step();
        fetch(2, 32'h408, ins(32'h408), ins(32'h40C), 1);
        step();
        fetch(1, 32'h410, ins(32'h410), 32'h0, 1);
        step();
        check("t4_count5", 32'(count_o), 5);
        StallD_i = 1'b0;
        Flush_i  = 1'b1;
        fetch(2, 32'h500, ins(32'h500), ins(32'h504), 0);
        step();
        idle();
        check("t4_count", 32'(count_o), 0);
        check("t4_valid", 32'(ValidD_o), 0);
        check("t4_valid2", 32'(ValidD2_o), 0);
        check("t4_ready", 32'(fetch_ready_o), 1);

        // Stream 20 pairs with random stall/hold
        n   = 0;
        cyc = 0;
        while ((n < 20 || count_o != 0) && cyc < 400) begin
            fetch_valid_i = 1'b0;
            StallD_i      = ($urandom_range(0, 3) == 0);
            Slot2Hold_i   = ($urandom_range(0, 2) == 0);
            if (n < 20 && fetch_ready_o) begin
                fetch(2, 32'(8 * n), ins(32'(8 * n)), ins(32'(8 * n + 4)), 1);
                n++;
            end
            step();
            cyc++;
        end
        idle();
        check("t5_issued", 32'(n), 20);
        check("t5_count", 32'(count_o), 0);
        check("t5_sb_empty", 32'(sbq.size()), 0);

        // Single entry: slot 2 invalid
        StallD_i = 1'b1;
        fetch(1, 32'h40, ins(32'h40), 32'h0, 1);
        step();
        fetch_valid_i = 1'b0;
        check("t6_valid", 32'(ValidD_o), 1);
        check("t6_pc", PCD_o, 32'h40);
        check("t6_valid2", 32'(ValidD2_o), 0);
        check("t6_instr2", InstrD2_o, NOP);
        check("t6_pc2", PCD2_o, 0);
`ifdef ISSUE_QUEUE_BYPASS_EN
        fetch(1, 32'h44, ins(32'h44), 32'h0, 1);
        #1;
        check("t6_byp_pc2", PCD2_o, 32'h44);
        check("t6_byp_valid2", 32'(ValidD2_o), 1);
        step();
`endif
        idle();
        step();
        step();
        check("t6_count", 32'(count_o), 0);
        check("t6_sb_empty", 32'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
